// File: rtl/ram1_bus_pkg.sv
// Shared types and defaults for the Ram1 SRAM / UART bus sequencer.
package ram1_bus_pkg;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SRD   = 4'd1;
  localparam logic [3:0] S_SWR   = 4'd2;
  localparam logic [3:0] S_SHOLD = 4'd3;
  localparam logic [3:0] S_URD   = 4'd4;
  localparam logic [3:0] S_UWR   = 4'd5;
  localparam logic [3:0] S_UHOLD = 4'd6;
  localparam logic [3:0] S_UWAIT = 4'd7;
  localparam logic [3:0] S_USTAT = 4'd8;
  localparam logic [3:0] S_RESP  = 4'd9;

  typedef enum logic [3:0] {
    IDLE  = S_IDLE,
    SRD   = S_SRD,
    SWR   = S_SWR,
    SHOLD = S_SHOLD,
    URD   = S_URD,
    UWR   = S_UWR,
    UHOLD = S_UHOLD,
    UWAIT = S_UWAIT,
    USTAT = S_USTAT,
    RESP  = S_RESP
  } state_t;

  localparam logic [15:0] UART_DATA_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_DEF = 16'hBF01;

  // Status accesses win over everything, so a store there becomes a plain ack.
  function automatic state_t decode(input logic [15:0] addr, input logic we,
                                    input logic [15:0] udata, input logic [15:0] ustat);
    if (addr == ustat) return USTAT;
    if (addr == udata) return we ? UWR : URD;
    return we ? SWR : SRD;
  endfunction

  function automatic logic [3:0] ld_val(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/ram1_bus_ctrl_if.sv
// CPU-side request/response channel of the Ram1 bus sequencer.
interface ram1_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ram1_strobe_timer.sv
// Strobe-width down-counter: load CYCLES-1, count to zero, saturate there.
module ram1_strobe_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       count,
  output logic       done
);
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= 4'd0;
    else if (load)                cnt <= load_val;
    else if (count && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign done = (cnt == 4'd0);
endmodule

// File: rtl/ram1_bus_ctrl.sv
// Ram1 SRAM / UART bus sequencer: one request at a time, registered pins.
// Optional build macro RAM1_UART_WAIT_EN: UART store ack waits for tbre&&tsre.
module ram1_bus_ctrl
  import ram1_bus_pkg::*;
#(
  parameter int          RD_CYCLES = 2,
  parameter int          WR_CYCLES = 2,
  parameter logic [15:0] UART_DATA = UART_DATA_DEF,
  parameter logic [15:0] UART_STAT = UART_STAT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  ram1_bus_ctrl_if.slave    bus,
  output logic [17:0]       Ram1Addr,
  inout  wire  [15:0]       Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN,
  output logic              rdn,
  output logic              wrn,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre
);
  localparam logic [3:0] RD_LD = ld_val(RD_CYCLES);
  localparam logic [3:0] WR_LD = ld_val(WR_CYCLES);

  state_t      state, state_nxt;
  logic        accept;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        drive_q;
  logic        tmr_load, tmr_count, tmr_done;

  assign bus.req_ready = (state == IDLE) && !RST;
  assign accept        = bus.req_valid && bus.req_ready;
  assign tmr_count     = state inside {SRD, SWR, URD, UWR};

  // Only the sequencer drives in write phases; OE/rdn phases never overlap them.
  assign Ram1Data = drive_q ? wdata_q : 16'hzzzz;

  ram1_strobe_timer u_tmr (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (bus.req_we ? WR_LD : RD_LD),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = decode(bus.req_addr, bus.req_we, UART_DATA, UART_STAT);
        tmr_load  = 1'b1;
      end
      SRD:   if (tmr_done) state_nxt = RESP;
      SWR:   if (tmr_done) state_nxt = SHOLD;
      SHOLD: state_nxt = RESP;
      URD:   if (tmr_done) state_nxt = RESP;
      UWR:   if (tmr_done) state_nxt = UHOLD;
`ifdef RAM1_UART_WAIT_EN
      UHOLD: state_nxt = UWAIT;
      UWAIT: if (tbre && tsre) state_nxt = RESP;
`else
      UHOLD: state_nxt = RESP;
`endif
      USTAT: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are decoded from the next state so strobes move on the same edge as the FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Ram1EN        <= 1'b1;
      Ram1OE        <= 1'b1;
      Ram1WE        <= 1'b1;
      rdn           <= 1'b1;
      wrn           <= 1'b1;
      drive_q       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 16'h0000;
      Ram1Addr      <= 18'h0;
      we_q          <= 1'b0;
      wdata_q       <= 16'h0000;
    end else begin
      Ram1EN        <= !(state_nxt inside {SRD, SWR, SHOLD});
      Ram1OE        <= (state_nxt != SRD);
      Ram1WE        <= (state_nxt != SWR);
      rdn           <= (state_nxt != URD);
      wrn           <= (state_nxt != UWR);
      drive_q       <= state_nxt inside {SWR, SHOLD, UWR, UHOLD};
      bus.rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        Ram1Addr <= {2'b00, bus.req_addr};
        we_q     <= bus.req_we;
        wdata_q  <= bus.req_wdata;
      end
      if (state == SRD && tmr_done)
        bus.rsp_rdata <= Ram1Data;
      if (state == URD && tmr_done)
        bus.rsp_rdata <= {8'h00, Ram1Data[7:0]};
      if (state == USTAT && !we_q)
        bus.rsp_rdata <= {14'b0, data_ready, tbre & tsre};
    end
  end
endmodule
